// File: rtl/arb_muxnx1.sv
// rtl/arb_muxnx1.sv - N:1 registered mux with valid/ready handshake, fixed or round-robin grant.
// Optional XFER_COUNT statistics output when ARB_MUXNX1_STATS_EN is defined.
module arb_muxnx1 #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 MODE,
  input  logic [SELW-1:0]      SELECT,
  input  logic [N-1:0]         IN_VALID,
  input  logic [N*WIDTH-1:0]   IN_DATA,
  output logic [N-1:0]         IN_READY,
  output logic                 OUT_VALID,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic [SELW-1:0]      OUT_SEL,
  input  logic                 OUT_READY
`ifdef ARB_MUXNX1_STATS_EN
  ,
  output logic [15:0]          XFER_COUNT
`endif
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SELW-1:0]   out_sel_q,   out_sel_d;
  logic [SELW-1:0]   rr_ptr_q,    rr_ptr_d;

  logic              load_en;
  logic              grant_vld;
  logic [SELW-1:0]   grant_idx;
  logic              xfer_in;
  logic [WIDTH-1:0]  sel_data;
  int                scan_idx;

  assign load_en = !out_valid_q || OUT_READY;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (!MODE) begin
      // Out-of-range SELECT values match no channel and therefore grant nothing.
      for (int i = 0; i < N; i++) begin
        if (IN_VALID[i] && (SELECT == SELW'(i))) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        scan_idx = (int'(rr_ptr_q) + k) % N;
        if (!grant_vld && IN_VALID[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(scan_idx);
        end
      end
    end
  end

  // Reset gates the accept strobes so no producer believes a word was taken.
  assign xfer_in  = !RESET && load_en && grant_vld;
  assign sel_data = IN_DATA[int'(grant_idx)*WIDTH +: WIDTH];

  always_comb begin
    IN_READY = '0;
    for (int i = 0; i < N; i++) begin
      IN_READY[i] = xfer_in && (grant_idx == SELW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer_in) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = grant_idx;
      if (MODE) begin
        rr_ptr_d = grant_idx;
      end
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign OUT_SEL   = out_sel_q;

`ifdef ARB_MUXNX1_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (out_valid_q && OUT_READY && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign XFER_COUNT = xfer_count_q;
`endif

endmodule

// File: tb/tb_arb_muxnx1.sv
// tb/tb_arb_muxnx1.sv - directed and random checks of arb_muxnx1 with a word scoreboard.
// Exercises XFER_COUNT as well when ARB_MUXNX1_STATS_EN is defined.
module tb_arb_muxnx1;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  select;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
`ifdef ARB_MUXNX1_STATS_EN
  logic [15:0] xfer_count;
  logic [15:0] m_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bit         m_ov;
  logic [7:0] m_od;
  logic [1:0] m_os;
  int         m_rr;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  arb_muxnx1 #(.WIDTH(8), .N(4), .SELW(2)) dut (
    .CLK       (clk),
    .RESET     (reset),
    .MODE      (mode),
    .SELECT    (select),
    .IN_VALID  (in_valid),
    .IN_DATA   (in_data),
    .IN_READY  (in_ready),
    .OUT_VALID (out_valid),
    .OUT_DATA  (out_data),
    .OUT_SEL   (out_sel),
    .OUT_READY (out_ready)
`ifdef ARB_MUXNX1_STATS_EN
    ,
    .XFER_COUNT(xfer_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_grant(output bit v, output int g);
    v = 0;
    g = 0;
    if (!mode) begin
      if (in_valid[select]) begin
        v = 1;
        g = int'(select);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (!v && in_valid[c]) begin
          v = 1;
          g = c;
        end
      end
    end
  endtask

  // One clock: check at the falling edge, advance the model, return 1 after the rising edge.
  task automatic cycle();
    bit         v;
    int         g;
    bit         load;
    logic [3:0] er;
    logic [9:0] w;
    @(negedge clk);
    exp_grant(v, g);
    load = !m_ov || out_ready;
    er = (!reset && load && v) ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_sel", 32'(out_sel), 32'(m_os));
`ifdef ARB_MUXNX1_STATS_EN
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
    if (!reset && m_ov && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("sb_word", 32'({out_sel, out_data}), 32'(w));
      end
    end
    if (reset) begin
      m_ov = 0;
      m_od = 8'h00;
      m_os = 2'd0;
      m_rr = 3;
      sb.delete();
`ifdef ARB_MUXNX1_STATS_EN
      m_cnt = 16'h0000;
`endif
    end else begin
`ifdef ARB_MUXNX1_STATS_EN
      if (m_ov && out_ready && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      if (er != 4'b0000) begin
        m_ov = 1;
        m_od = in_data[g*8 +: 8];
        m_os = 2'(g);
        if (mode) m_rr = g;
        sb.push_back({m_os, m_od});
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    select    = 2'd0;
    in_valid  = 4'b1111;
    in_data   = 32'h44332211;
    out_ready = 1'b1;
    m_ov = 0; m_od = 8'h00; m_os = 2'd0; m_rr = 3;
`ifdef ARB_MUXNX1_STATS_EN
    m_cnt = 16'h0000;
`endif
    @(posedge clk);
    #1;

    // Reset with every channel requesting.
    repeat (3) cycle();

    // Fixed select of channel 2.
    reset    = 1'b0;
    select   = 2'd2;
    in_data  = 32'h11A52233;
    in_valid = 4'b0100;
    cycle();
    chk("fix_valid", 32'(out_valid), 32'd1);
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b0000;
    cycle();

    // Fixed select of a channel that is not valid.
    select   = 2'd1;
    in_valid = 4'b1101;
    repeat (2) cycle();
    chk("fix_inv_valid", 32'(out_valid), 32'd0);

    // Round-robin fairness with all channels requesting.
    mode     = 1'b1;
    in_valid = 4'b1111;
    in_data  = 32'hD3C2B1A0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_sel", 32'(out_sel), 32'(i % 4));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Back-pressure with a held word from channel 1.
    mode     = 1'b0;
    select   = 2'd1;
    in_valid = 4'b0010;
    in_data  = 32'h00003C00;
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data  = $urandom;
      in_valid = 4'($urandom_range(0, 15));
      cycle();
      chk("bp_data", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1;
    in_valid  = 4'b0000;
    cycle();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      mode      = 1'($urandom_range(0, 1));
      select    = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end

    // Reset in the middle of a stall discards the held word.
    mode      = 1'b0;
    select    = 2'd3;
    in_valid  = 4'b1000;
    in_data   = 32'h5A000000;
    out_ready = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    in_valid = 4'b0000;
    cycle();
    chk("rst_stall_valid", 32'(out_valid), 32'd0);

`ifdef ARB_MUXNX1_STATS_EN
    mode      = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (70001) cycle();
    chk("stats_sat", 32'(xfer_count), 32'hFFFF);
    reset = 1'b1;
    cycle();
    chk("stats_clr", 32'(xfer_count), 32'h0);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb_muxnx1.md
# arb_muxnx1

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshaking and a selectable arbitration mode. It generalises the CPU's 2:1 operand mux to N sources. Each selected word is captured in a one-entry output register and held until the consumer accepts it. It sits between multiple producers (register file read ports, immediate path, ALU result forwarding) and a single consumer that may stall.

## Interface
- WIDTH, 8, data width of every input and the output
- N, 4, number of input channels (2..16)
- SELW, 2, select/index width; must equal ceil(log2(N))

- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- MODE  input  1  0 = fixed select via SELECT, 1 = round-robin arbitration
- SELECT  input  SELW  channel index used when MODE=0
- IN_VALID  input  N  per-channel data valid
- IN_DATA  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- IN_READY  output  N  one-hot (or zero) accept strobe per channel, combinational
- OUT_VALID  output  1  output register holds a word
- OUT_DATA  output  WIDTH  registered data
- OUT_SEL  output  SELW  index of the channel that supplied OUT_DATA
- OUT_READY  input  1  consumer accepts the word when OUT_VALID & OUT_READY

## Operation
- load_en = !OUT_VALID | OUT_READY: output register is empty or being drained this cycle.
- Grant, MODE=0: grant = SELECT if IN_VALID[SELECT], else no grant. SELECT >= N gives no grant.
- Grant, MODE=1: first channel with IN_VALID set, scanning upward from (rr_ptr+1) mod N and wrapping around.
- IN_READY[g] = load_en & grant valid; all other IN_READY bits are 0. IN_READY never depends on IN_DATA.
- Transfer in: on IN_VALID[g] & IN_READY[g], next edge loads OUT_DATA = IN_DATA[g], OUT_SEL = g, OUT_VALID = 1.
- Transfer out: on OUT_VALID & OUT_READY with no new transfer in, next edge clears OUT_VALID. OUT_DATA and OUT_SEL hold their last values.
- Simultaneous drain and fill: OUT_VALID stays 1 and the new word replaces the old one. This sustains full throughput.
- Stall: while OUT_VALID & !OUT_READY, all IN_READY are 0 and OUT_DATA, OUT_SEL and OUT_VALID are stable.
- rr_ptr (SELW bits) updates to g only on a transfer in while MODE=1. In MODE=0 it holds.
- A MODE change takes effect on the next grant evaluation. A word already in the register is unaffected.
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, rr_ptr=N-1 (so channel 0 has first priority). RESET asserted mid-stall discards the held word.

## Timing
- Latency 1 cycle: input accepted at edge k, visible on OUT_* after edge k.
- Throughput 1 word/cycle while OUT_READY=1.
- Combinational paths: IN_VALID, MODE, SELECT, OUT_READY -> IN_READY. No combinational path from any input to OUT_*.
- RESET dominates every other input at the edge.

## Configuration
- ARB_MUXNX1_STATS_EN defined: adds output XFER_COUNT [15:0], reset 0.
  - Increments on each transfer out (OUT_VALID & OUT_READY).
  - Saturates at 16'hFFFF.
  - Cleared by RESET.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: assert RESET with all IN_VALID=1 -> OUT_VALID=0, OUT_DATA=0, OUT_SEL=0, IN_READY=0 during reset.
- Fixed select, N=4, WIDTH=8, MODE=0, SELECT=2, IN_DATA ch2=8'hA5, IN_VALID=4'b0100, OUT_READY=1 -> IN_READY=4'b0100; after 1 edge OUT_VALID=1, OUT_DATA=8'hA5, OUT_SEL=2.
- Fixed select, invalid channel: MODE=0, SELECT=1, IN_VALID=4'b1101 -> IN_READY=0 and OUT_VALID stays 0.
- Round-robin fairness: MODE=1, IN_VALID=4'b1111 held, OUT_READY=1 for 8 cycles -> OUT_SEL sequence 0,1,2,3,0,1,2,3 with OUT_VALID=1 every cycle.
- Back-pressure: load ch1=8'h3C, hold OUT_READY=0 for 5 cycles while changing IN_DATA -> OUT_DATA stays 8'h3C and IN_READY=0 throughout; OUT_READY=1 with no IN_VALID -> OUT_VALID drops after 1 edge.
- Stats (macro defined): 70000 accepted transfers -> XFER_COUNT=16'hFFFF. RESET -> XFER_COUNT=0.
